clkdiv_ctrl: RTL
================

# clkdiv_ctrl

Run-time controller for the power-of-two clock divider. It owns the divider counter, generates the divided clock `dclk_o` at a ratio of 2^(CNT_W−sel), and accepts ratio-change requests over a valid/ready handshake. Every ratio change and every enable/disable is deferred to a period boundary, so `dclk_o` never produces a runt or stretched pulse. It sits between the system control logic that requests ratios and any logic clocked or strobed by `dclk_o`.

## Interface
- `CNT_W`, default 8: divider counter width. Maximum ratio is 2^CNT_W. Must be ≥ 4.
- `SEL_RST`, default 2'b00: value of `sel_o` after reset.
- `clk_i`  in  1: system clock.
- `rstn_i`  in  1: reset, asynchronous, active-low.
- `en_i`  in  1: run enable, level-sensitive.
- `req_valid_i`  in  1: ratio-change request valid.
- `req_sel_i`  in  2: requested select. Divide ratio = 2^(CNT_W−sel).
- `req_ready_o`  out  1: request can be accepted this cycle.
- `ack_o`  out  1: one-cycle pulse in the cycle after a request takes effect.
- `sel_o`  out  2: currently applied select.
- `busy_o`  out  1: a change is pending (state PEND).
- `dclk_o`  out  1: divided clock, 50 % duty, driven directly by a flop.
- `tc_o`  out  1: one-cycle pulse on the last cycle of each `dclk_o` period.

## Operation
- Definitions:
  - div = 2^(CNT_W−sel_o); half = div/2.
  - `cnt` counts 0..div−1 and wraps.
  - tc = RUN or PEND, and cnt == div−1.
- `dclk_o` is high exactly in the cycles where cnt ≥ half. It is registered from next-state values and is never a combinational mux of `cnt` bits.
- States:
  - IDLE: `cnt` is held at 0 and `dclk_o` = 0.
    - `en_i` = 1 → RUN. `cnt` starts at 0.
    - A request accepted in IDLE is applied in the next cycle: `sel_o` updates and `ack_o` pulses.
  - RUN: `cnt` advances every cycle.
    - Accepted request with req_sel == sel_o → `ack_o` next cycle. The counter is not disturbed.
    - Accepted request with a different select, on a non-tc cycle → stored as pending, go to PEND.
    - Accepted request with a different select, on a tc cycle → applied at that boundary.
    - tc with `en_i` = 0 → IDLE.
  - PEND: `cnt` keeps advancing and `req_ready_o` = 0.
    - At tc: `sel_o` ← pending, `cnt` ← 0, `ack_o` pulses.
    - Next state is RUN, or IDLE if `en_i` = 0 in that cycle.
- `req_ready_o` is combinational from state: 1 in IDLE and RUN, 0 in PEND.
- Handshake: a transfer occurs when valid & ready. The requester must hold `req_sel_i` while valid is high and ready is low.
- Deasserting `en_i` mid-period never truncates it. The current period completes, then the block goes to IDLE.
- Reset clears everything, including any pending select.
  - State = IDLE, `cnt` = 0, `sel_o` = SEL_RST.
  - `dclk_o`, `tc_o`, `ack_o` and `busy_o` = 0; `req_ready_o` = 1.

## Timing
- `en_i` sampled high in IDLE at cycle n:
  - cycle n+1 has cnt = 0;
  - first `dclk_o` high cycle is n+1+half;
  - rising edges are then spaced by exactly div cycles.
- Same-select request accepted at cycle n: `ack_o` = 1 at n+1.
- Request applied at tc at cycle m:
  - `sel_o` (new value), cnt = 0, `ack_o` = 1 and `dclk_o` = 0 all at m+1;
  - first period at the new ratio begins at m+1.
- Worst-case request latency is one full old period plus one cycle.
- `tc_o` is asserted in the tc cycle itself. It is 0 in IDLE.
- Request accepted in a tc cycle together with `en_i` = 0: the new select is applied, `ack_o` pulses, and the next state is IDLE.

## Structure
- Package `clkdiv_pkg` holds:
  - the state enum (IDLE, RUN, PEND);
  - `SEL_W` = 2;
  - function `div_of(sel, cnt_w)` returning 2^(cnt_w−sel), also used by the testbench.
- Sub-module `clkdiv_counter` holds `cnt`, tc detection and the `dclk_o` flop. Inputs are `sel`, `run` and `clr`.
- `clkdiv_ctrl` holds the FSM, pending register and handshake.

## Test plan
- Reset, SEL_RST = 0, `en_i` = 1, 10 ns clock → consecutive `dclk_o` rising edges 2560 ns apart; `tc_o` every 256 cycles; `dclk_o` high for exactly 128 cycles.
- Mid-period request for sel = 3 → `req_ready_o` = 0 and `busy_o` = 1 until tc; `ack_o` the cycle after tc; following periods are 32 cycles; no high or low phase shorter than 16 cycles at any point.
- Request for sel equal to the current `sel_o` in RUN → `ack_o` next cycle, `cnt` phase unchanged, period unchanged.
- `en_i` dropped at cycle 10 of a 256-cycle period → `dclk_o` completes its high phase, then stays 0 from the cycle after tc. Then a request for sel = 2 in IDLE → `sel_o` = 2 and `ack_o` next cycle. Then `en_i` = 1 → periods of 64 cycles.
- `rstn_i` asserted while in PEND → all outputs take reset values asynchronously; after release, `sel_o` = SEL_RST and no `ack_o` is produced for the discarded request.
- Request for sel = 1 presented in the tc cycle of RUN with `en_i` = 0 in the same cycle → `sel_o` = 1 and `ack_o` next cycle; state IDLE; `dclk_o` stays 0.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the run-time power-of-two clock divider.
`timescale 1ns/1ps
package clkdiv_pkg;

    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    // Divide ratio for a select value: 2^(cnt_w - sel).
    function automatic int unsigned div_of(input logic [SEL_W-1:0] sel, input int cnt_w);
        return 32'd1 << (cnt_w - int'(sel));
    endfunction

endpackage

// File: rtl/clkdiv_counter.sv
// Divider counter: period counting, terminal-count detect and the registered divided clock.
`timescale 1ns/1ps
module clkdiv_counter
    import clkdiv_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] sel,
    input  logic             run,
    input  logic             clr,
    output logic             tc,
    output logic             dclk
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] last;
    logic [CNT_W-1:0] half;
    int unsigned      div;

    always_comb begin
        div  = div_of(sel, CNT_W);
        last = CNT_W'(div - 32'd1);
        half = CNT_W'(div >> 1);
    end

    assign tc = run && (cnt == last);

    always_comb begin
        if (clr || !run || (cnt == last)) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    // dclk is decoded from the next count so it lines up with cnt yet comes straight off a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            dclk <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            dclk <= (cnt_next >= half);
        end
    end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Divider controller: FSM, pending-select register and request handshake around clkdiv_counter.
`timescale 1ns/1ps
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int         CNT_W   = 8,
    parameter logic [1:0] SEL_RST = 2'b00
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             en_i,
    input  logic             req_valid_i,
    input  logic [SEL_W-1:0] req_sel_i,
    output logic             req_ready_o,
    output logic             ack_o,
    output logic [SEL_W-1:0] sel_o,
    output logic             busy_o,
    output logic             dclk_o,
    output logic             tc_o
);

    state_t           state;
    state_t           state_next;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] sel_next;
    logic [SEL_W-1:0] pend;
    logic             ack;
    logic             ack_set;
    logic             load_sel;
    logic             store;
    logic             accept;
    logic             run;
    logic             tc;

    assign req_ready_o = (state != PEND);
    assign busy_o      = (state == PEND);
    assign run         = (state != IDLE);
    assign accept      = req_valid_i && (state != PEND);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Disable and ratio changes only leave RUN/PEND on a terminal-count cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (en_i) state_next = RUN;
            end
            RUN: begin
                if (accept && (req_sel_i != sel) && !tc) state_next = PEND;
                else if (tc && !en_i)                    state_next = IDLE;
            end
            PEND: begin
                if (tc) state_next = en_i ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_sel = 1'b0;
        sel_next = sel;
        store    = 1'b0;
        ack_set  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    load_sel = 1'b1;
                    sel_next = req_sel_i;
                    ack_set  = 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    if (req_sel_i == sel) begin
                        ack_set = 1'b1;
                    end else if (tc) begin
                        load_sel = 1'b1;
                        sel_next = req_sel_i;
                        ack_set  = 1'b1;
                    end else begin
                        store = 1'b1;
                    end
                end
            end
            PEND: begin
                if (tc) begin
                    load_sel = 1'b1;
                    sel_next = pend;
                    ack_set  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sel  <= SEL_RST;
            pend <= '0;
            ack  <= 1'b0;
        end else begin
            ack <= ack_set;
            if (load_sel) sel  <= sel_next;
            if (store)    pend <= req_sel_i;
        end
    end

    clkdiv_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk  (clk_i),
        .rst_n(rstn_i),
        .sel  (sel),
        .run  (run),
        .clr  (load_sel),
        .tc   (tc),
        .dclk (dclk_o)
    );

    assign tc_o  = tc;
    assign sel_o = sel;
    assign ack_o = ack;

endmodule
